// File: rtl/ttl_nand_arbiter.sv
// Round-robin front end that shares one WIDTH_IN-input NAND evaluator among
// BLOCKS requesters using a 4-phase Req/Grant handshake and a one-cycle Done pulse.
module ttl_nand_arbiter #(
  parameter int BLOCKS     = 3,
  parameter int WIDTH_IN   = 3,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                         Clk,
  input  logic                         Clear_bar,
  input  logic [BLOCKS-1:0]            Req,
  input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
  output logic [BLOCKS-1:0]            Grant,
  output logic [BLOCKS-1:0]            Done,
  output logic [BLOCKS-1:0]            Y,
  output logic                         Busy
);

  localparam int PW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RELEASE
  } state_t;

  state_t state, next_state;

  logic [PW-1:0]       last_ptr;
  logic [PW-1:0]       grant_idx;
  logic [PW-1:0]       sel_idx;
  logic [PW-1:0]       cand_idx;
  logic                sel_valid;
  logic [WIDTH_IN-1:0] operands;
  logic [WIDTH_IN-1:0] sel_operands;
  logic [WIDTH_IN-1:0] block_ops [BLOCKS];
  logic [BLOCKS-1:0]   done_reg;
  logic [BLOCKS-1:0]   y_reg;

  // A_2D is input-major; regroup it so each block's operands form one word.
  for (genvar b = 0; b < BLOCKS; b++) begin : g_block
    for (genvar i = 0; i < WIDTH_IN; i++) begin : g_input
      assign block_ops[b][i] = A_2D[i*BLOCKS + b];
    end
  end

  // First pending request strictly after the last served block, wrapping.
  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    cand_idx  = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      cand_idx = PW'((int'(last_ptr) + 1 + i) % BLOCKS);
      if (!sel_valid && Req[cand_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign sel_operands = block_ops[sel_idx];

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sel_valid) next_state = EVAL;
      EVAL:    next_state = RELEASE;
      RELEASE: if (!Req[grant_idx]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    Grant = '0;
    Busy  = (state != IDLE);
    if (state != IDLE) begin
      Grant[grant_idx] = 1'b1;
    end
  end

  // Operands are captured only at the grant edge; Done is cleared every edge
  // unless the evaluation completes on that edge.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      last_ptr  <= PW'(BLOCKS - 1);
      grant_idx <= '0;
      operands  <= '0;
      done_reg  <= '0;
      y_reg     <= '0;
    end else begin
      done_reg <= '0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            grant_idx <= sel_idx;
            operands  <= sel_operands;
          end
        end
        EVAL: begin
          y_reg[grant_idx]    <= ~&operands;
          done_reg[grant_idx] <= 1'b1;
        end
        RELEASE: begin
          if (!Req[grant_idx]) last_ptr <= grant_idx;
        end
        default: ;
      endcase
    end
  end

  assign Done = done_reg;
  assign #(DELAY_RISE, DELAY_FALL) Y = y_reg;

endmodule

// File: tb/tb_ttl_nand_arbiter.sv
// Directed self-checking bench for ttl_nand_arbiter (BLOCKS=3, WIDTH_IN=3).
// Observed vector in every comparison is {Grant, Done, Y, Busy}.
module tb_ttl_nand_arbiter;

  logic       Clk;
  logic       Clear_bar;
  logic [2:0] Req;
  logic [8:0] A_2D;
  logic [2:0] Grant;
  logic [2:0] Done;
  logic [2:0] Y;
  logic       Busy;

  int pass_cnt;
  int total_cnt;

  ttl_nand_arbiter #(
    .BLOCKS(3), .WIDTH_IN(3), .DELAY_RISE(0), .DELAY_FALL(0)
  ) dut (
    .Clk(Clk), .Clear_bar(Clear_bar), .Req(Req), .A_2D(A_2D),
    .Grant(Grant), .Done(Done), .Y(Y), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Clear_bar = 1'b0;
    Req       = 3'b000;
    A_2D      = 9'b0;
    tick();
    tick();
    Clear_bar = 1'b1;
  endtask

  task automatic test_reset();
    Clear_bar = 1'b0;
    Req       = 3'b111;
    A_2D      = 9'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total_cnt++;
      if ({Grant, Done, Y, Busy} !== 10'b000_000_000_0)
        $display("FAIL reset_hold[%0d]: got %b want %b", c, {Grant, Done, Y, Busy}, 10'b000_000_000_0);
      else pass_cnt++;
    end
    Clear_bar = 1'b1;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b001_000_000_1)
      $display("FAIL reset_release_grant: got %b want %b", {Grant, Done, Y, Busy}, 10'b001_000_000_1);
    else pass_cnt++;
    Req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_single();
    do_reset();
    A_2D = 9'b001_001_001;
    Req  = 3'b001;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b001_000_000_1)
      $display("FAIL single_grant: got %b want %b", {Grant, Done, Y, Busy}, 10'b001_000_000_1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b001_001_000_1)
      $display("FAIL single_done: got %b want %b", {Grant, Done, Y, Busy}, 10'b001_001_000_1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b001_000_000_1)
      $display("FAIL single_done_clear: got %b want %b", {Grant, Done, Y, Busy}, 10'b001_000_000_1);
    else pass_cnt++;
    Req = 3'b000;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b000_000_000_0)
      $display("FAIL single_release: got %b want %b", {Grant, Done, Y, Busy}, 10'b000_000_000_0);
    else pass_cnt++;
  endtask

  task automatic test_result_value();
    do_reset();
    A_2D = 9'b000_001_001;
    Req  = 3'b001;
    tick();
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b001_001_001_1)
      $display("FAIL result_110: got %b want %b", {Grant, Done, Y, Busy}, 10'b001_001_001_1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b001_000_001_1)
      $display("FAIL result_done_once: got %b want %b", {Grant, Done, Y, Busy}, 10'b001_000_001_1);
    else pass_cnt++;
    Req = 3'b000;
    tick();
    A_2D = 9'b0;
    Req  = 3'b010;
    tick();
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b010_010_011_1)
      $display("FAIL result_block1: got %b want %b", {Grant, Done, Y, Busy}, 10'b010_010_011_1);
    else pass_cnt++;
    Req = 3'b000;
    tick();
    A_2D = 9'b001_001_001;
    Req  = 3'b001;
    tick();
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b001_001_010_1)
      $display("FAIL result_111_others_kept: got %b want %b", {Grant, Done, Y, Busy}, 10'b001_001_010_1);
    else pass_cnt++;
    Req = 3'b000;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b000_000_010_0)
      $display("FAIL result_idle_hold: got %b want %b", {Grant, Done, Y, Busy}, 10'b000_000_010_0);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    logic [9:0] exp_vec [10];
    logic [2:0] req_after [10];
    exp_vec[0] = 10'b001_000_000_1;  req_after[0] = 3'b111;
    exp_vec[1] = 10'b001_001_001_1;  req_after[1] = 3'b110;
    exp_vec[2] = 10'b000_000_001_0;  req_after[2] = 3'b110;
    exp_vec[3] = 10'b010_000_001_1;  req_after[3] = 3'b110;
    exp_vec[4] = 10'b010_010_011_1;  req_after[4] = 3'b100;
    exp_vec[5] = 10'b000_000_011_0;  req_after[5] = 3'b100;
    exp_vec[6] = 10'b100_000_011_1;  req_after[6] = 3'b100;
    exp_vec[7] = 10'b100_100_111_1;  req_after[7] = 3'b011;
    exp_vec[8] = 10'b000_000_111_0;  req_after[8] = 3'b011;
    exp_vec[9] = 10'b001_000_111_1;  req_after[9] = 3'b000;
    do_reset();
    A_2D = 9'b0;
    Req  = 3'b111;
    for (int s = 0; s < 10; s++) begin
      tick();
      total_cnt++;
      if ({Grant, Done, Y, Busy} !== exp_vec[s])
        $display("FAIL fairness_step%0d: got %b want %b", s, {Grant, Done, Y, Busy}, exp_vec[s]);
      else pass_cnt++;
      Req = req_after[s];
    end
    tick();
    tick();
  endtask

  task automatic test_operand_latch();
    do_reset();
    A_2D = 9'b010_010_010;
    Req  = 3'b010;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b010_000_000_1)
      $display("FAIL latch_grant: got %b want %b", {Grant, Done, Y, Busy}, 10'b010_000_000_1);
    else pass_cnt++;
    A_2D = 9'b000_000_000;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b010_010_000_1)
      $display("FAIL latch_result: got %b want %b", {Grant, Done, Y, Busy}, 10'b010_010_000_1);
    else pass_cnt++;
    Req = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    A_2D = 9'b0;
    Req  = 3'b100;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b100_000_000_1)
      $display("FAIL midreset_grant: got %b want %b", {Grant, Done, Y, Busy}, 10'b100_000_000_1);
    else pass_cnt++;
    Clear_bar = 1'b0;
    #1;
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b000_000_000_0)
      $display("FAIL midreset_async: got %b want %b", {Grant, Done, Y, Busy}, 10'b000_000_000_0);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b000_000_000_0)
      $display("FAIL midreset_no_done: got %b want %b", {Grant, Done, Y, Busy}, 10'b000_000_000_0);
    else pass_cnt++;
    Clear_bar = 1'b1;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b100_000_000_1)
      $display("FAIL midreset_regrant: got %b want %b", {Grant, Done, Y, Busy}, 10'b100_000_000_1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b100_100_100_1)
      $display("FAIL midreset_complete: got %b want %b", {Grant, Done, Y, Busy}, 10'b100_100_100_1);
    else pass_cnt++;
    Req = 3'b000;
    tick();
    total_cnt++;
    if ({Grant, Done, Y, Busy} !== 10'b000_000_100_0)
      $display("FAIL midreset_release: got %b want %b", {Grant, Done, Y, Busy}, 10'b000_000_100_0);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    Clear_bar = 1'b0;
    Req       = 3'b000;
    A_2D      = 9'b0;
    test_reset();
    test_single();
    test_result_value();
    test_fairness();
    test_operand_latch();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
